// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - opcode constants, sequencer states and counter sizing for the multiply issue controller
package mult_pkg;

  localparam logic [5:0] OP_RR    = 6'd2;
  localparam logic [5:0] OP_MULUI = 6'd12;
  localparam logic [5:0] OP_MULSI = 6'd13;
  localparam logic [5:0] FN_MULU  = 6'd24;
  localparam logic [5:0] FN_MULS  = 6'd25;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  // Wait counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - issue/retire sequencer between decode and the iterative multiplier
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_ir,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_imm,
  input  logic [4:0]  req_rt,
  output logic        mul_ld,
  output logic [31:0] mul_ir,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [31:0] mul_imm,
  input  logic [63:0] mul_o,
  input  logic        mul_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_rt,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic        res_err,
  output logic        busy
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_inc;
  logic          drop;
  logic          started;
  logic          accept;
  logic          legal;
  logic          timed_out;

  function automatic logic is_mul(input logic [5:0] op, input logic [5:0] funct);
    return ((op == OP_RR) && ((funct == FN_MULU) || (funct == FN_MULS))) ||
           (op == OP_MULUI) || (op == OP_MULSI);
  endfunction

  assign legal        = is_mul(req_ir[31:26], req_ir[5:0]);
  assign wait_cnt_inc = wait_cnt + CW'(1);
  assign timed_out    = (wait_cnt_inc == TIMEOUT_CNT);

  // mul_done gating keeps a timed-out multiplier from being reissued before it settles.
  assign req_ready = (state == S_IDLE) && started && mul_done && !flush;
  assign accept    = req_valid && req_ready;
  assign mul_ld    = (state == S_LAUNCH);
  assign res_valid = (state == S_HOLD) && !flush;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = legal ? S_LAUNCH : S_HOLD;
      end
      S_LAUNCH: state_nx = S_ARM;
      S_ARM:    state_nx = S_WAIT;
      S_WAIT: begin
        // A dropped op still has to wait out the multiplier before returning to IDLE.
        if (mul_done || timed_out) state_nx = (drop || flush) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (flush || res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      started  <= 1'b0;
      wait_cnt <= '0;
      drop     <= 1'b0;
      mul_ir   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_imm  <= '0;
      res_rt   <= '0;
      res_lo   <= '0;
      res_hi   <= '0;
      res_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mul_ir  <= req_ir;
            mul_a   <= req_a;
            mul_b   <= req_b;
            mul_imm <= req_imm;
            res_rt  <= req_rt;
            drop    <= 1'b0;
            if (!legal) begin
              res_err <= 1'b1;
              res_lo  <= '0;
              res_hi  <= '0;
            end
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          drop     <= drop || flush;
        end
        S_ARM: begin
          drop <= drop || flush;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt_inc;
          drop     <= drop || flush;
          if (mul_done) begin
            res_lo  <= mul_o[31:0];
            res_hi  <= mul_o[63:32];
            res_err <= 1'b0;
          end else if (timed_out) begin
            res_lo  <= '0;
            res_hi  <= '0;
            res_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
